// File: rtl/axi_lite_sram.sv
// rtl/axi_lite_sram.sv - word-addressed SRAM slave with AXI-lite-style read and write channels
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   araddr/arvalid/arready    read address channel
//   rdata/rresp/rvalid/rready read data channel (rresp 00 OKAY, 10 SLVERR)
//   awaddr/awvalid/awready    write address channel
//   wdata/wstrb/wvalid/wready write data channel (wstrb[3:0] used, [7:4] ignored)
//   bresp/bvalid/bready       write response channel
//
// Optional feature: define AXI_SRAM_RAND_DELAY_EN to take each transaction's
// service latency from a 16-bit LFSR instead of RD_LAT / WR_LAT.
module axi_lite_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LAT      = 2,
    parameter int          WR_LAT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [7:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] BASE_EXT  = {1'b0, ADDR_BASE};
    localparam logic [32:0] LIMIT_EXT = BASE_EXT + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // 33-bit compare so a window touching the top of the address space cannot wrap.
    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= BASE_EXT) && ({1'b0, a} < LIMIT_EXT);
    endfunction

    function automatic logic [IDX_W-1:0] to_index(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    logic [4:0] rd_lat_sel;
    logic [4:0] wr_lat_sel;

`ifdef AXI_SRAM_RAND_DELAY_EN
    // Fibonacci LFSR, taps 16,14,13,11; free-running outside reset.
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
    assign rd_lat_sel = lfsr[4:0];
    assign wr_lat_sel = lfsr[4:0];
`else
    assign rd_lat_sel = 5'(RD_LAT);
    assign wr_lat_sel = 5'(WR_LAT);
`endif

    logic unused_strb;
    assign unused_strb = ^wstrb[7:4];

    // ---------------- read path ----------------
    r_state_t         r_state, r_state_nxt;
    logic [4:0]       rcnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = !rst;
                if (arvalid) begin
                    r_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rcnt == 5'd0) begin
                    r_state_nxt = R_RESP;
                end
            end
            R_RESP: begin
                rvalid = 1'b1;
                if (rready) begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt  <= 5'd0;
            r_idx <= '0;
            r_ok  <= 1'b0;
            rdata <= 32'd0;
            rresp <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (arvalid) begin
                        r_idx <= to_index(araddr);
                        r_ok  <= in_range(araddr);
                        rcnt  <= rd_lat_sel;
                    end
                end
                R_WAIT: begin
                    if (rcnt == 5'd0) begin
                        // Non-blocking sample: a same-edge write commit is not yet visible.
                        rdata <= r_ok ? mem[r_idx] : 32'd0;
                        rresp <= r_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        rcnt <= rcnt - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- write path ----------------
    w_state_t         w_state, w_state_nxt;
    logic [4:0]       wcnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_ok;
    logic             aw_got;
    logic             w_got;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !rst && !aw_got;
                wready  = !rst && !w_got;
                // Leave as soon as both halves are in, counting this edge's handshakes.
                if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
                    w_state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wcnt == 5'd0) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt     <= 5'd0;
            w_idx    <= '0;
            w_ok     <= 1'b0;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            w_data_q <= 32'd0;
            w_strb_q <= 4'd0;
            bresp    <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        w_idx  <= to_index(awaddr);
                        w_ok   <= in_range(awaddr);
                        aw_got <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb[3:0];
                        w_got    <= 1'b1;
                    end
                    if (w_state_nxt == W_WAIT) begin
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                        wcnt   <= wr_lat_sel;
                    end
                end
                W_WAIT: begin
                    if (wcnt == 5'd0) begin
                        bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        wcnt <= wcnt - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Commit is gated by rst so a reset landing on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && w_state == W_WAIT && wcnt == 5'd0 && w_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) begin
                    mem[w_idx][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_sram.sv
// tb/tb_axi_lite_sram.sv - self-checking bench for axi_lite_sram
module tb_axi_lite_sram;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    always #5 clk = ~clk;

    axi_lite_sram #(
        .ADDR_BASE  (32'h8000_0000),
        .DEPTH_WORDS(4096),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int tests = 0;
    int fails = 0;

    logic [33:0] rexp_q[$];
    logic [1:0]  bexp_q[$];
    logic [33:0] r_e;
    logic [1:0]  b_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop an expectation whenever a response handshake is about to happen.
    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            if (rexp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL r_unexpected: got rvalid with data %0h, expected none", rdata);
            end else begin
                r_e = rexp_q.pop_front();
                check("rdata", {32'd0, rdata}, {32'd0, r_e[31:0]});
                check("rresp", {62'd0, rresp}, {62'd0, r_e[33:32]});
            end
        end
        if (!rst && bvalid && bready) begin
            if (bexp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected: got bvalid with bresp %0h, expected none", bresp);
            end else begin
                b_e = bexp_q.pop_front();
                check("bresp", {62'd0, bresp}, {62'd0, b_e});
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                           output int lat);
        rexp_q.push_back({er, ed});
        araddr  = a;
        arvalid = 1'b1;
        check("arready_idle", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rvalid) begin
            tests++;
            fails++;
            $display("FAIL rd_timeout: got no rvalid after %0d cycles, expected %0d", lat, RD_LAT + 1);
        end
`ifndef AXI_SRAM_RAND_DELAY_EN
        check("rd_lat", 64'(lat), 64'(RD_LAT + 1));
`endif
        @(posedge clk); #1;
    endtask

    task automatic wait_bvalid(output int cyc);
        cyc = 0;
        while (!bvalid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bvalid) begin
            tests++;
            fails++;
            $display("FAIL wr_timeout: got no bvalid after %0d cycles, expected %0d", cyc, WR_LAT + 1);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                            input logic [1:0] er);
        int cyc;
        bexp_q.push_back(er);
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        check("awready_idle", {63'd0, awready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_bvalid(cyc);
`ifndef AXI_SRAM_RAND_DELAY_EN
        check("wr_lat", 64'(cyc), 64'(WR_LAT + 1));
`endif
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                       input logic [31:0] ed, input logic [1:0] er);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
        vecs.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arready"}, {63'd0, arready}, 64'd0);
        check({tag, "_awready"}, {63'd0, awready}, 64'd0);
        check({tag, "_wready"},  {63'd0, wready},  64'd0);
        check({tag, "_rvalid"},  {63'd0, rvalid},  64'd0);
        check({tag, "_bvalid"},  {63'd0, bvalid},  64'd0);
        check({tag, "_rdata"},   {32'd0, rdata},   64'd0);
        check({tag, "_rresp"},   {62'd0, rresp},   64'd0);
        check({tag, "_bresp"},   {62'd0, bresp},   64'd0);
    endtask

    initial begin
        int lat;
        int cyc;
        int distinct;
        bit seen[33];

        //   wr  addr            data            strb   exp_data        exp_resp
        add(1, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 32'h0,          2'b00);
        add(0, 32'h8000_0010, 32'h0,         8'h00, 32'hDEAD_BEEF, 2'b00);
        add(1, 32'h8000_0010, 32'h1122_3344, 8'h05, 32'h0,          2'b00);
        add(0, 32'h8000_0010, 32'h0,         8'h00, 32'hDE22_BE44, 2'b00);
        add(1, 32'h8000_0004, 32'hFFFF_FFFF, 8'h0F, 32'h0,          2'b00);
        add(1, 32'h8000_0004, 32'h0000_0000, 8'h0A, 32'h0,          2'b00);
        add(1, 32'h8000_0004, 32'h0000_0000, 8'hF0, 32'h0,          2'b00);
        add(0, 32'h8000_0006, 32'h0,         8'h00, 32'h00FF_00FF, 2'b00);
        add(1, 32'h8000_0000, 32'h55AA_55AA, 8'h0F, 32'h0,          2'b00);
        add(1, 32'h8000_4000, 32'hCAFE_F00D, 8'h0F, 32'h0,          2'b10);
        add(0, 32'h8000_0000, 32'h0,         8'h00, 32'h55AA_55AA, 2'b00);
        add(0, 32'h7FFF_FFFC, 32'h0,         8'h00, 32'h0,          2'b10);
        add(0, 32'h8000_4000, 32'h0,         8'h00, 32'h0,          2'b10);
        add(1, 32'h8000_3FFC, 32'h0A0B_0C0D, 8'h0F, 32'h0,          2'b00);
        add(0, 32'h8000_3FFC, 32'h0,         8'h00, 32'h0A0B_0C0D, 2'b00);
        add(1, 32'hFFFF_FFFC, 32'h0000_0001, 8'h0F, 32'h0,          2'b10);
        add(0, 32'h0000_0000, 32'h0,         8'h00, 32'h0,          2'b10);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp, lat);
            end
        end

        // W three cycles ahead of AW; single response, correct data.
        bexp_q.push_back(2'b00);
        awaddr = 32'h8000_0040;
        wdata  = 32'hA5A5_0001;
        wstrb  = 8'h0F;
        wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("w_first_wready", {63'd0, wready}, 64'd0);
        check("w_first_awready", {63'd0, awready}, 64'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("w_first_bvalid", {63'd0, bvalid}, 64'd0);
        awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wait_bvalid(cyc);
`ifndef AXI_SRAM_RAND_DELAY_EN
        check("w_first_lat", 64'(cyc), 64'(WR_LAT + 1));
`endif
        @(posedge clk); #1;
        check("w_first_single_b", {63'd0, bvalid}, 64'd0);
        do_read(32'h8000_0040, 32'hA5A5_0001, 2'b00, lat);

        // rready held low for 5 cycles in R_RESP.
        rready = 1'b0;
        rexp_q.push_back({2'b00, 32'hDE22_BE44});
        araddr  = 32'h8000_0010;
        arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_rvalid", {63'd0, rvalid}, 64'd1);
            check("stall_rdata", {32'd0, rdata}, {32'd0, 32'hDE22_BE44});
            check("stall_arready", {63'd0, arready}, 64'd0);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1;
        check("release_rvalid", {63'd0, rvalid}, 64'd0);
        check("release_arready", {63'd0, arready}, 64'd1);

        // Reset while the write is in W_WAIT: no commit, no response.
        do_write(32'h8000_0020, 32'h1111_1111, 8'h0F, 2'b00);
        awaddr  = 32'h8000_0020;
        wdata   = 32'h2222_2222;
        wstrb   = 8'h0F;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("rst_mid_no_b", {63'd0, bvalid}, 64'd0);
        do_read(32'h8000_0020, 32'h1111_1111, 2'b00, lat);

`ifdef AXI_SRAM_RAND_DELAY_EN
        for (int i = 0; i < 33; i++) seen[i] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            do_read(32'h8000_0010, 32'hDE22_BE44, 2'b00, lat);
            if (lat >= 1 && lat <= 32) seen[lat] = 1'b1;
            else check("rand_lat_range", 64'(lat), 64'd1);
        end
        distinct = 0;
        for (int i = 0; i < 33; i++) distinct += int'(seen[i]);
        check("rand_distinct_gt8", {63'd0, distinct > 8}, 64'd1);
`else
        distinct = 0;
        seen[0] = 1'b0;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rexp_drained", 64'(rexp_q.size()), 64'd0);
        check("bexp_drained", 64'(bexp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_lite_sram.md
# axi_lite_sram

AXI-lite-style word-addressed SRAM slave that answers the load/store master channels driven by the write-back stage of the multicycle core. It serves one read and one write transaction at a time, on independent read and write paths, with a programmable (or pseudo-random) service latency. It returns SLVERR for addresses outside its window. It is the memory end of the data path and also serves as the latency-stress target for the core's handshake logic.

## Interface
- ADDR_BASE, 32'h8000_0000: byte address of word 0.
- DEPTH_WORDS, 4096: number of 32-bit words; power of two.
- RD_LAT, 2: fixed read service cycles (0..31).
- WR_LAT, 2: fixed write service cycles (0..31).

- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address accept
- rdata  out  32  read data
- rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  master accepts read data
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address accept
- wdata  in  32  write data
- wstrb  in  8  byte enables; [3:0] used, [7:4] ignored
- wvalid  in  1  write data valid
- wready  out  1  write data accept
- bresp  out  2  write response, same encoding as rresp
- bvalid  out  1  write response valid
- bready  in  1  master accepts response

## Operation
- Index = (addr - ADDR_BASE) >> 2; addr[1:0] ignored. In range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS (33-bit compare, no wrap).
- Read FSM R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready=1. On arvalid&arready, latch address, load rcnt with latency, go to R_WAIT.
  - R_WAIT: rcnt decrements each cycle. At rcnt==0, sample mem[index] into rdata (or 0 with SLVERR if out of range) and go to R_RESP.
  - R_RESP: rvalid=1; rdata/rresp held stable until rvalid&rready, then go to R_IDLE.
- Write FSM W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order or in the same cycle. Once both are captured, load wcnt and go to W_WAIT.
  - W_WAIT: wcnt decrements. At 0, commit the byte-masked write (byte i written iff wstrb[i]), or drop it if out of range, and go to W_RESP.
  - W_RESP: bvalid=1 with bresp until bvalid&bready, then go to W_IDLE.
- The read and write paths are fully independent and may be busy at the same time.
- Same-edge read sample and write commit to the same word: read returns the old data.
- Memory contents are not reset and are uninitialised.

## Timing
- AR handshake at edge k: rvalid first high after edge k+LAT+1; LAT=0 gives rvalid one cycle after the handshake.
- Write: last of AW/W captured at edge k: bvalid high after edge k+LAT+1.
- arready/awready/wready are combinational from FSM state and forced 0 while rst=1.
- Reset values: rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0. FSMs go to R_IDLE/W_IDLE, counters to 0, captured flags cleared.
- Reset mid-transaction aborts it: a pending write is not committed and no response is issued.
- Master holding arvalid after its handshake: not re-accepted until R_IDLE is re-entered. A master must drop arvalid by the rvalid&rready cycle.
- rready and bready may be held high permanently.

## Configuration
- AXI_SRAM_RAND_DELAY_EN defined:
  - Per-transaction latency = lfsr[4:0] (0..31), sampled at the AR handshake (read) or the W_IDLE exit (write).
  - lfsr is a 16-bit Fibonacci LFSR, taps 16,14,13,11, reset to 16'hACE1, advancing every non-reset cycle.
  - RD_LAT and WR_LAT are ignored.
- Undefined: fixed RD_LAT / WR_LAT; no LFSR is instantiated.

## Test plan
- Write 32'hDEAD_BEEF to 32'h8000_0010 with wstrb 4'hF, then read 32'h8000_0010 -> bresp=00, rdata=32'hDEAD_BEEF, rresp=00, rvalid after RD_LAT+1 cycles (2,2 config).
- wstrb 4'b0101 writing 32'h1122_3344 over 32'hDEAD_BEEF -> readback 32'hDE22_BE44.
- W presented 3 cycles before AW, then AW -> bvalid exactly WR_LAT+1 cycles after AW capture; single commit.
- Read 32'h7FFF_FFFC and write 32'h8000_4000 (DEPTH 4096) -> rresp=10, rdata=0; bresp=10, memory unchanged.
- rready held low 5 cycles in R_RESP -> rvalid/rdata stable throughout; arready=0 until release.
- rst asserted in W_WAIT -> bvalid stays 0, target word keeps old value; with AXI_SRAM_RAND_DELAY_EN, 100 reads all complete with latencies spanning more than 8 distinct values.
